// File: rtl/bank_xbar_pipe_if.sv
// +--------------------------------------------------------------------------+
// | bank_xbar_pipe_if : handshake/address bundle for the bank crossbar       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

interface bank_xbar_pipe_if #(
    parameter int N  = 4,
    parameter int AW = 7
);
    localparam int SW = $clog2(N);

    logic            in_valid;
    logic            in_ready;
    logic [N*AW-1:0] in_addr;
    logic [N*SW-1:0] sel;
    logic            out_valid;
    logic            out_ready;
    logic [N*AW-1:0] out_addr;
    logic            out_conflict;

    modport master (
        output in_valid, in_addr, sel, out_ready,
        input  in_ready, out_valid, out_addr, out_conflict
    );

    modport slave (
        input  in_valid, in_addr, sel, out_ready,
        output in_ready, out_valid, out_addr, out_conflict
    );
endinterface

`default_nettype wire

// File: rtl/bank_xbar_pipe.sv
// +--------------------------------------------------------------------------+
// | bank_xbar_pipe : N-lane bank-address crossbar with a skid output stage   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module bank_xbar_pipe #(
    parameter int N              = 4,
    parameter int AW             = 7,
    parameter int CONFLICT_CHECK = 1,
    parameter int CW             = 8
) (
    input  wire logic          clk,
    input  wire logic          rst,
    bank_xbar_pipe_if.slave    bus,
    input  wire logic          clr_err,
    output logic [CW-1:0]      err_cnt
);
    localparam int SW = $clog2(N);
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    logic [N*AW-1:0] routed;
    logic            dup;
    logic            in_fire;
    logic            out_fire;

    logic            main_valid;
    logic [N*AW-1:0] main_addr;
    logic            main_conf;
    logic            skid_valid;
    logic [N*AW-1:0] skid_addr;
    logic            skid_conf;

    always_comb begin
        routed = '0;
        for (int j = 0; j < N; j++) begin
            routed[j*AW +: AW] = bus.in_addr[int'(bus.sel[j*SW +: SW])*AW +: AW];
        end
    end

    if (CONFLICT_CHECK != 0) begin : g_conflict
        always_comb begin
            dup = 1'b0;
            for (int j = 0; j < N; j++) begin
                for (int k = j + 1; k < N; k++) begin
                    if (bus.sel[j*SW +: SW] == bus.sel[k*SW +: SW]) begin
                        dup = 1'b1;
                    end
                end
            end
        end
    end else begin : g_no_conflict
        assign dup = 1'b0;
    end

    // Ready depends only on the skid register (and reset), never on out_ready.
    assign bus.in_ready     = !skid_valid && !rst;
    assign bus.out_valid    = main_valid;
    assign bus.out_addr     = main_addr;
    assign bus.out_conflict = main_conf;

    assign in_fire  = bus.in_valid && bus.in_ready;
    assign out_fire = main_valid && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid <= 1'b0;
            main_addr  <= '0;
            main_conf  <= 1'b0;
            skid_valid <= 1'b0;
            skid_addr  <= '0;
            skid_conf  <= 1'b0;
        end else if (out_fire || !main_valid) begin
            // Main slot is free this cycle: refill from skid first to keep order.
            if (skid_valid) begin
                main_valid <= 1'b1;
                main_addr  <= skid_addr;
                main_conf  <= skid_conf;
                skid_valid <= 1'b0;
            end else if (in_fire) begin
                main_valid <= 1'b1;
                main_addr  <= routed;
                main_conf  <= dup;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (in_fire) begin
            skid_valid <= 1'b1;
            skid_addr  <= routed;
            skid_conf  <= dup;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_err) begin
            err_cnt <= '0;
        end else if (in_fire && dup && (err_cnt != CNT_MAX)) begin
            err_cnt <= err_cnt + CW'(1);
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_bank_xbar_pipe.sv
// +--------------------------------------------------------------------------+
// | tb_bank_xbar_pipe : directed + random bench with a queue-based model     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_bank_xbar_pipe;
    localparam int N  = 4;
    localparam int AW = 7;
    localparam int SW = $clog2(N);
    localparam int CW = 2;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clr_err = 1'b0;
    logic [CW-1:0] err_cnt;

    always #5 clk = ~clk;

    bank_xbar_pipe_if #(.N(N), .AW(AW)) bus ();

    bank_xbar_pipe #(
        .N(N), .AW(AW), .CONFLICT_CHECK(1), .CW(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .clr_err(clr_err),
        .err_cnt(err_cnt)
    );

    logic [AW-1:0] a_l [N];
    int            s_l [N];

    always_comb begin
        bus.in_addr = '0;
        bus.sel     = '0;
        for (int i = 0; i < N; i++) begin
            bus.in_addr[i*AW +: AW] = a_l[i];
            bus.sel[i*SW +: SW]     = SW'(s_l[i]);
        end
    end

    typedef struct {
        logic [N*AW-1:0] addr;
        logic            conf;
    } beat_t;

    beat_t q[$];
    int    exp_cnt = 0;
    int    checks  = 0;
    int    errs    = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Beat as the spec describes it: each output lane copies its selected input
    // lane; a conflict means fewer distinct sources than lanes.
    function automatic beat_t route();
        beat_t b;
        bit    seen [N];
        int    distinct = 0;
        b.addr = '0;
        for (int i = 0; i < N; i++) seen[i] = 1'b0;
        for (int j = 0; j < N; j++) begin
            b.addr[j*AW +: AW] = a_l[s_l[j]];
            if (!seen[s_l[j]]) distinct++;
            seen[s_l[j]] = 1'b1;
        end
        b.conf = (distinct < N);
        return b;
    endfunction

    task automatic step(input logic v, input logic ordy, input logic clr, input logic r);
        bit    rdy_e;
        bit    inf;
        bit    outf;
        beat_t b;
        bus.in_valid  = v;
        bus.out_ready = ordy;
        clr_err       = clr;
        rst           = r;
        #1;
        rdy_e = (q.size() < 2) && !r;
        check("in_ready", 64'(bus.in_ready), 64'(rdy_e));
        check("out_valid", 64'(bus.out_valid), 64'(q.size() > 0));
        if (q.size() > 0) begin
            check("out_addr", 64'(bus.out_addr), 64'(q[0].addr));
            check("out_conflict", 64'(bus.out_conflict), 64'(q[0].conf));
        end
        check("err_cnt", 64'(err_cnt), 64'(exp_cnt));
        b    = route();
        inf  = v && rdy_e;
        outf = (q.size() > 0) && ordy;
        @(posedge clk);
        if (r) begin
            q.delete();
            exp_cnt = 0;
        end else begin
            if (outf) void'(q.pop_front());
            if (inf) q.push_back(b);
            if (clr) exp_cnt = 0;
            else if (inf && b.conf && exp_cnt < CNT_MAX) exp_cnt++;
        end
        @(negedge clk);
    endtask

    task automatic rand_addrs();
        for (int i = 0; i < N; i++) a_l[i] = AW'($urandom);
    endtask

    task automatic ident_sel();
        for (int j = 0; j < N; j++) s_l[j] = j;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            a_l[i] = '0;
            s_l[i] = i;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_out_addr", 64'(bus.out_addr), 64'h0);
        check("reset_out_conflict", 64'(bus.out_conflict), 64'h0);
        @(negedge clk);

        // identity then reverse routing
        for (int i = 0; i < N; i++) a_l[i] = AW'(i);
        ident_sel();
        step(1, 1, 0, 0);
        #1;
        check("identity_const", 64'(bus.out_addr), 64'({7'h03, 7'h02, 7'h01, 7'h00}));
        for (int j = 0; j < N; j++) s_l[j] = N - 1 - j;
        step(1, 1, 0, 0);
        #1;
        check("reverse_const", 64'(bus.out_addr), 64'({7'h00, 7'h01, 7'h02, 7'h03}));
        step(0, 1, 0, 0);

        // broadcast conflict
        for (int j = 0; j < N; j++) s_l[j] = 2;
        a_l[2] = 7'h55;
        step(1, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);

        // back-pressure: A, B accepted, C held until space frees
        ident_sel();
        for (int k = 0; k < 3; k++) begin
            rand_addrs();
            step(1, 0, 0, 0);
        end
        step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        step(0, 1, 0, 0);
        repeat (3) step(0, 1, 0, 0);

        // back-to-back throughput
        for (int k = 0; k < 16; k++) begin
            rand_addrs();
            s_l[0] = k % N;
            step(1, 1, 0, 0);
        end
        repeat (2) step(0, 1, 0, 0);

        // counter saturation, then clear coinciding with a conflicting accept
        for (int j = 0; j < N; j++) s_l[j] = 0;
        repeat (5) step(1, 1, 0, 0);
        step(1, 1, 1, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);

        // reset with both entries full
        ident_sel();
        rand_addrs();
        step(1, 0, 0, 0);
        rand_addrs();
        step(1, 0, 0, 0);
        step(0, 0, 0, 1);
        repeat (3) step(0, 1, 0, 0);

        // randomized traffic
        for (int k = 0; k < 400; k++) begin
            rand_addrs();
            if ($urandom_range(1, 0) == 0) begin
                for (int j = 0; j < N; j++) s_l[j] = (j + k) % N;
            end else begin
                for (int j = 0; j < N; j++) s_l[j] = int'($urandom_range(N - 1, 0));
            end
            step(($urandom_range(3, 0) != 0),
                 ($urandom_range(2, 0) != 0),
                 ($urandom_range(31, 0) == 0),
                 ($urandom_range(63, 0) == 0));
        end
        repeat (3) step(0, 1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
        $finish;
    end
endmodule

`default_nettype wire
